timer_cmd_tx: RTL and testbench
===============================

TIMER_CMD_TX -- requirements
Module: timer_cmd_tx

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: areset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: cmd_valid  in  1  command request from host.
REQ-004 SHALL have: cmd_delay  in  4  delay value for receiver, sampled at handshake.
REQ-005 SHALL have: cmd_ready  out  1  high only in IDLE; handshake = cmd_valid & cmd_ready at rising edge.
REQ-006 SHALL have: d  out  1  registered serial line to the timer receiver.
REQ-007 SHALL have: done  in  1  level from receiver, high while receiver waits for ack.
REQ-008 SHALL have: ack  out  1  registered one-cycle acknowledge to receiver.
REQ-009 SHALL have: busy  out  1  high in every state except IDLE.
REQ-010 SHALL have: err  out  1  sticky timeout flag; present only with TIMER_TX_TIMEOUT_EN, otherwise tied 0.

Function
REQ-011 SHALL implement FSM states IDLE, PRE, DATA, WAIT_DONE, ACK.
REQ-012 IDLE: d=0, ack=0; on handshake latch cmd_delay, clear bit counter, go to PRE.
REQ-013 PRE: 4 cycles, d = 1,1,0,1 (preamble 4'b1101, MSB first), then DATA.
REQ-014 DATA: 4 cycles, d = latched delay[3], [2], [1], [0], then WAIT_DONE.
REQ-015 First preamble bit SHALL appear on d in the cycle after the handshake edge; all 8 serial bits on consecutive cycles, no gaps.
REQ-016 WAIT_DONE: d=0; when done=1 sampled, go to ACK; done during PRE/DATA/IDLE ignored.
REQ-017 ACK: exactly one cycle, ack=1, d=0, then IDLE.
REQ-018 cmd_valid while busy SHALL be ignored (no latch, no queueing); cmd_delay changes after handshake have no effect.
REQ-019 Back-to-back: a new handshake in the first IDLE cycle after ACK SHALL be accepted; minimum command-to-command spacing = 8 serial + WAIT_DONE(>=1) + 1 ACK + 1 IDLE cycles.
REQ-020 Bit counter 2 bits wide, wraps 3->0 at each PRE->DATA and DATA->WAIT_DONE transition.

Reset
REQ-021 areset_n=0 SHALL immediately force IDLE, d=0, ack=0, busy=0, cmd_ready=1 after release, err=0, counters=0.
REQ-022 Reset mid-transfer SHALL abandon the command with no ack and no partial bits after assertion.

Configuration
REQ-023 With TIMER_TX_TIMEOUT_EN defined: watchdog counts cycles in WAIT_DONE; at TIMEOUT_CYCLES without done, SHALL go to ACK (forcing receiver release) and set err.
REQ-024 err SHALL stay 1 until the next accepted handshake, which clears it in the same edge.
REQ-025 Timer watchdog clears on entry to WAIT_DONE; done and timeout in the same cycle SHALL count as done (err not set).
REQ-026 Without TIMER_TX_TIMEOUT_EN: no watchdog logic, WAIT_DONE waits indefinitely, err constant 0.

Structure
REQ-027 Package timer_tx_pkg SHALL hold: state enum, PREAMBLE=4'b1101, PRE_LEN=4, DATA_LEN=4, TIMEOUT_CYCLES=16100 (exceeds max receiver count 16000), watchdog width 14.
REQ-028 One sub-module timer_tx_watchdog (clear, enable -> expired), instantiated only under TIMER_TX_TIMEOUT_EN.

Verification
REQ-029 cmd_delay=4'b0101 handshake at cycle 0 -> d cycles 1..8 = 1,1,0,1,0,1,0,1; busy=1 from cycle 1.
REQ-030 done raised cycle 20 -> ack=1 exactly cycle 21, IDLE/cmd_ready=1 cycle 22; new cmd_delay=4'b1111 at cycle 22 -> d=1 cycles 23..30 except cycle 25=0.
REQ-031 cmd_valid pulsed with 4'b0000 during DATA -> ignored; serialized bits unchanged.
REQ-032 areset_n low during PRE bit 3 -> d=0 and ack=0 same cycle; after release, no ack issued, cmd_ready=1.
REQ-033 With TIMER_TX_TIMEOUT_EN, done held 0 -> ack pulse 16100 cycles after WAIT_DONE entry, err=1; next handshake clears err.
REQ-034 Closed loop with the timer receiver, delay=4'b0010 -> receiver counts 3000 cycles, done, ack, both return idle; repeat 10 random delays, no lockup.

Source files
------------

// File: rtl/timer_tx_pkg.sv
// Shared types and constants for the timer command transmitter.
// TIMEOUT_CYCLES is only consumed when TIMER_TX_TIMEOUT_EN is defined.
package timer_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_DATA      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4
    } state_t;

    localparam logic [3:0] PREAMBLE = 4'b1101;
    localparam int         PRE_LEN  = 4;
    localparam int         DATA_LEN = 4;

    localparam logic [1:0] PRE_LAST  = 2'(PRE_LEN - 1);
    localparam logic [1:0] DATA_LAST = 2'(DATA_LEN - 1);

    // Must exceed the longest receiver count (16000 cycles).
    localparam int                WDOG_W         = 14;
    localparam logic [WDOG_W-1:0] TIMEOUT_CYCLES = 14'd16100;
    localparam logic [WDOG_W-1:0] TIMEOUT_LAST   = TIMEOUT_CYCLES - 14'd1;

    // Serial order is MSB first; for a 2-bit index, 3-idx equals ~idx.
    function automatic logic msb_first_bit(input logic [3:0] word, input logic [1:0] idx);
        return word[~idx];
    endfunction

endpackage

// File: rtl/timer_tx_watchdog.sv
// Cycle watchdog for the WAIT_DONE phase; expired is high during the
// last cycle of the TIMEOUT_CYCLES window.
module timer_tx_watchdog
    import timer_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != TIMEOUT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == TIMEOUT_LAST);

endmodule

// File: rtl/timer_cmd_tx.sv
// Serialises a 4-bit delay command (preamble + data) to a timer receiver and
// completes the done/ack exchange. Optional watchdog: TIMER_TX_TIMEOUT_EN.
module timer_cmd_tx
    import timer_tx_pkg::*;
(
    input  logic       clk,
    input  logic       areset_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_delay,
    output logic       cmd_ready,
    output logic       d,
    input  logic       done,
    output logic       ack,
    output logic       busy,
    output logic       err,
    output logic [2:0] dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, and cmd_valid
    // seen while not ready is dropped, never queued.
    logic handshake;
    logic timeout;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] delay_q, delay_d;
    logic       d_q, d_d;
    logic       ack_q, ack_d;

    assign cmd_ready = (state_q == ST_IDLE);
    assign handshake = cmd_valid && cmd_ready;

`ifdef TIMER_TX_TIMEOUT_EN
    logic wdog_clear;
    logic wdog_expired;
    logic err_q, err_d;

    assign wdog_clear = (state_d == ST_WAIT_DONE) && (state_q != ST_WAIT_DONE);

    timer_tx_watchdog u_wdog (
        .clk     (clk),
        .rst_n   (areset_n),
        .clear   (wdog_clear),
        .enable  (state_q == ST_WAIT_DONE),
        .expired (wdog_expired)
    );

    assign timeout = wdog_expired;

    // done wins over a coinciding timeout, so err only flags a real stall.
    always_comb begin
        err_d = err_q;
        if (handshake) begin
            err_d = 1'b0;
        end else if ((state_q == ST_WAIT_DONE) && !done && timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d = ST_PRE;
                    cnt_d   = 2'd0;
                    delay_d = cmd_delay;
                end
            end
            ST_PRE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (done || timeout) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so d and ack are true flops
    // and the first preamble bit appears in the cycle after the handshake.
    always_comb begin
        d_d   = 1'b0;
        ack_d = 1'b0;
        case (state_d)
            ST_PRE:  d_d   = msb_first_bit(PREAMBLE, cnt_d);
            ST_DATA: d_d   = msb_first_bit(delay_d, cnt_d);
            ST_ACK:  ack_d = 1'b1;
            default: begin
                d_d   = 1'b0;
                ack_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            delay_q <= 4'd0;
            d_q     <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            d_q     <= d_d;
            ack_q   <= ack_d;
        end
    end

    assign d         = d_q;
    assign ack       = ack_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Bench for timer_cmd_tx: transaction-level model, directed timing checks,
// random stimulus and a closed loop with a behavioural timer receiver.
module tb_timer_cmd_tx;

    localparam int TO_CYCLES = 16100;
`ifdef TIMER_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       areset_n;
    logic       cmd_valid;
    logic [3:0] cmd_delay;
    logic       man_done;
    logic       rx_en;
    logic       chk_en;
    wire        cmd_ready, d, ack, busy, err, done;
    wire  [2:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    timer_cmd_tx dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .cmd_valid (cmd_valid),
        .cmd_delay (cmd_delay),
        .cmd_ready (cmd_ready),
        .d         (d),
        .done      (done),
        .ack       (ack),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / time limit ----------------
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural receiver ----------------
    logic [7:0]  rx_sr;
    logic        rx_busy, rx_done;
    logic [3:0]  rx_delay;
    int          rx_cnt, rx_target;

    assign done = rx_en ? rx_done : man_done;

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n || !rx_en) begin
            rx_sr   <= 8'd0;
            rx_busy <= 1'b0;
            rx_done <= 1'b0;
            rx_cnt  <= 0;
        end else if (rx_done) begin
            if (ack) rx_done <= 1'b0;
        end else if (rx_busy) begin
            if (rx_cnt == rx_target - 1) begin
                rx_done <= 1'b1;
                rx_busy <= 1'b0;
            end else begin
                rx_cnt <= rx_cnt + 1;
            end
        end else if ({rx_sr[6:3], d} == 5'b0_1101 || {rx_sr[6:3]} == 4'b1101) begin
            if (rx_sr[6:3] == 4'b1101) begin
                rx_delay  <= {rx_sr[2:0], d};
                rx_target <= (int'({rx_sr[2:0], d}) + 1) * 1000;
                rx_busy   <= 1'b1;
                rx_cnt    <= 0;
                rx_sr     <= 8'd0;
            end else begin
                rx_sr <= {rx_sr[6:0], d};
            end
        end else begin
            rx_sr <= {rx_sr[6:0], d};
        end
    end

    // ---------------- transaction-level model ----------------
    // exp_q holds the serial bits still to appear on d, front = current bit.
    logic exp_q[$];
    bit   m_wait, m_ack, m_err;
    int   m_wd;

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            exp_q.delete();
            m_wait = 1'b0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_wd   = 0;
        end else if (m_ack) begin
            m_ack = 1'b0;
        end else if (m_wait) begin
            if (done) begin
                m_wait = 1'b0;
                m_ack  = 1'b1;
            end else if (TO_EN && m_wd == TO_CYCLES - 1) begin
                m_wait = 1'b0;
                m_ack  = 1'b1;
                m_err  = 1'b1;
            end else begin
                m_wd++;
            end
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                m_wait = 1'b1;
                m_wd   = 0;
            end
        end else if (cmd_valid) begin
            logic [7:0] word;
            word  = {4'b1101, cmd_delay};
            m_err = 1'b0;
            for (int i = 7; i >= 0; i--) exp_q.push_back(word[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic m_busy;
            m_busy = (exp_q.size() > 0) || m_wait || m_ack;
            chk("d",         d,         (exp_q.size() > 0) ? exp_q[0] : 1'b0);
            chk("ack",       ack,       m_ack);
            chk("busy",      busy,      m_busy);
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("err",       err,       m_err);
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send(input logic [3:0] dl);
        cmd_valid = 1'b1;
        cmd_delay = dl;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_delay = 4'($urandom_range(0, 15));
    endtask

    task automatic capture8(input bit inject, output logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            bits[7-i] = d;
            if (inject && i == 4) begin
                cmd_valid = 1'b1;
                cmd_delay = 4'b0000;
            end
            if (i == 5) cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic finish_with_done();
        bit seen;
        seen     = 1'b0;
        man_done = 1'b1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = ack;
        end
        man_done = 1'b0;
        chk("ack_seen", seen, 1'b1);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 areset_n = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] cap;
        int         lat;
        logic [3:0] dl;

        areset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_delay = 4'd0;
        man_done  = 1'b0;
        rx_en     = 1'b0;
        chk_en    = 1'b0;
        #1;
        chk("rst_d",     d,         1'b0);
        chk("rst_ack",   ack,       1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_err",   err,       1'b0);
        repeat (3) @(negedge clk);
        areset_n = 1'b1;
        chk("rst_ready", cmd_ready, 1'b1);
        chk_en = 1'b1;
        @(negedge clk);

        // Handshake in cycle 0 with 0101; done raised in cycle 20.
        send(4'b0101);
        chk("busy_cycle1", busy, 1'b1);
        capture8(1'b0, cap);
        chk("bits_0101", cap, 8'b1101_0101);
        repeat (11) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        chk("ack_cycle21", ack, 1'b1);
        man_done = 1'b0;
        @(negedge clk);
        chk("ack_cycle22",   ack,       1'b0);
        chk("ready_cycle22", cmd_ready, 1'b1);

        // Back-to-back 1111, with an ignored 0000 request during DATA.
        send(4'b1111);
        capture8(1'b1, cap);
        chk("bits_1111_ignored_cmd", cap, 8'b1101_1111);
        finish_with_done();

        // Reset during the fourth preamble bit abandons the command.
        send(4'b1010);
        repeat (3) @(negedge clk);
        chk("pre_bit3_before_rst", d, 1'b1);
        #2 areset_n = 1'b0;
        #1;
        chk("midrst_d",    d,    1'b0);
        chk("midrst_ack",  ack,  1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        areset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("postrst_ready", cmd_ready, 1'b1);

        // Random traffic with occasional asynchronous resets.
        for (int c = 0; c < 1200; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_delay = 4'($urandom_range(0, 15));
            man_done  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else @(negedge clk);
        end
        cmd_valid = 1'b0;
        man_done  = 1'b0;
        pulse_reset();
        @(negedge clk);

        if (TO_EN) begin
            // Watchdog: ack 16100 cycles after WAIT_DONE entry (cycle 9).
            send(4'b0011);
            lat = 0;
            for (int n = 1; n <= 16300 && lat == 0; n++) begin
                if (ack) lat = n;
                else @(negedge clk);
            end
            chk("timeout_ack_cycle", lat, 9 + TO_CYCLES);
            @(negedge clk);
            chk("timeout_err_set", err, 1'b1);
            send(4'b0001);
            chk("err_cleared", err, 1'b0);
            capture8(1'b0, cap);
            finish_with_done();
        end

        // Closed loop with the receiver: ack latency = 8 bits + detect + count + 1.
        rx_en = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 11; t++) begin
            dl = (t == 0) ? 4'b0010 : 4'($urandom_range(0, 3));
            send(dl);
            lat = 0;
            for (int n = 1; n <= 20000 && lat == 0; n++) begin
                if (ack) lat = n;
                else @(negedge clk);
            end
            chk("loop_ack_latency", lat, (int'(dl) + 1) * 1000 + 10);
            chk("loop_rx_delay", rx_delay, dl);
            @(negedge clk);
            chk("loop_idle", cmd_ready, 1'b1);
            chk("loop_rx_released", rx_done, 1'b0);
        end
        rx_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
